// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a word-addressed RAM with independent write and read burst engines.
// Optional AXI_SLAVE_ERR_EN: out-of-range/illegal bursts and wlast misplacement answer SLVERR.
module axi_slave_ram #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_ID_WIDTH-1:0]   axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]                axi_awlen,
    input  logic [2:0]                axi_awsize,
    input  logic [1:0]                axi_awburst,
    input  logic                      axi_awvalid,
    output logic                      axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                      axi_wlast,
    input  logic                      axi_wvalid,
    output logic                      axi_wready,
    output logic [AXI_ID_WIDTH-1:0]   axi_bid,
    output logic [1:0]                axi_bresp,
    output logic                      axi_bvalid,
    input  logic                      axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]   axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]                axi_arlen,
    input  logic [2:0]                axi_arsize,
    input  logic [1:0]                axi_arburst,
    input  logic                      axi_arvalid,
    output logic                      axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]                axi_rresp,
    output logic                      axi_rlast,
    output logic                      axi_rvalid,
    input  logic                      axi_rready
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA} rstate_e;

    logic [AXI_DATA_WIDTH-1:0] mem [0:DEPTH-1];

    function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        return MEM_DEPTH_LOG2'(a >> OFF);
    endfunction

    // WRAP keeps the upper address bits of the aligned window and wraps the offset inside it.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] a,
        input logic [7:0]                len,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_WIDTH-1:0] incr, mask, res;
        incr = AXI_ADDR_WIDTH'(1) << size;
        mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
        case (burst)
            2'b00:   res = a;
            2'b10:   res = (a & ~mask) | ((a + incr) & mask);
            default: res = a + incr;
        endcase
        return res;
    endfunction

    logic                      aw_err, ar_err, wlast_bad;
    logic                      w_last_beat;

    wstate_e                   wstate_q;
    logic                      awready_q, wready_q, bvalid_q;
    logic [AXI_ID_WIDTH-1:0]   wid_q, bid_q;
    logic [1:0]                bresp_q;
    logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]                wlen_q, wcnt_q;
    logic [2:0]                wsize_q;
    logic [1:0]                wburst_q;
    logic                      werr_q, wlast_err_q;

    rstate_e                   rstate_q;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [AXI_ID_WIDTH-1:0]   rid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;
    logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]                rlen_q, rcnt_q;
    logic [2:0]                rsize_q;
    logic [1:0]                rburst_q;
    logic                      rerr_q;

    logic aw_fire, w_fire, ar_fire, r_fire, mem_we;

    assign aw_fire     = axi_awvalid && awready_q;
    assign w_fire      = axi_wvalid && wready_q;
    assign ar_fire     = axi_arvalid && arready_q;
    assign r_fire      = rvalid_q && axi_rready;
    assign w_last_beat = (wcnt_q == wlen_q);
    assign mem_we      = w_fire && !werr_q;
    assign waddr_d     = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
    assign raddr_d     = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);

`ifdef AXI_SLAVE_ERR_EN
    // The whole burst footprint is contiguous, so checking its lowest and highest byte suffices.
    function automatic logic burst_err(
        input logic [AXI_ADDR_WIDTH-1:0] a,
        input logic [7:0]                len,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_WIDTH-1:0] span, lo, hi;
        logic                      bad;
        span = (AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size;
        lo   = a;
        hi   = a;
        bad  = 1'b0;
        case (burst)
            2'b01: hi = a + (AXI_ADDR_WIDTH'(len) << size);
            2'b10: begin
                lo  = a & ~(span - AXI_ADDR_WIDTH'(1));
                hi  = lo + span - AXI_ADDR_WIDTH'(1);
                bad = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
            end
            2'b11: bad = 1'b1;
            default: ;
        endcase
        if ((lo >> (MEM_DEPTH_LOG2 + OFF)) != '0 || (hi >> (MEM_DEPTH_LOG2 + OFF)) != '0)
            bad = 1'b1;
        return bad;
    endfunction

    assign aw_err    = burst_err(axi_awaddr, axi_awlen, axi_awsize, axi_awburst);
    assign ar_err    = burst_err(axi_araddr, axi_arlen, axi_arsize, axi_arburst);
    assign wlast_bad = (axi_wlast != w_last_beat);
`else
    logic unused_wlast;
    assign unused_wlast = axi_wlast;
    assign aw_err       = 1'b0;
    assign ar_err       = 1'b0;
    assign wlast_bad    = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb[b])
                    mem[word_idx(waddr_q)][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
        end
    end

    // Write engine: address latch, beat counting (count, not wlast, ends the burst), response hold.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q    <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            wid_q       <= '0;
            bid_q       <= '0;
            bresp_q     <= RESP_OKAY;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wcnt_q      <= '0;
            wsize_q     <= '0;
            wburst_q    <= '0;
            werr_q      <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        wid_q       <= axi_awid;
                        waddr_q     <= axi_awaddr;
                        wlen_q      <= axi_awlen;
                        wsize_q     <= axi_awsize;
                        wburst_q    <= axi_awburst;
                        wcnt_q      <= '0;
                        werr_q      <= aw_err;
                        wlast_err_q <= 1'b0;
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        wstate_q    <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        waddr_q <= waddr_d;
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= wid_q;
                            bresp_q  <= (werr_q || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end else begin
                            wcnt_q      <= wcnt_q + 8'd1;
                            wlast_err_q <= wlast_err_q | wlast_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Read engine: rdata is fetched on the edge that accepts the address or the previous beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rerr_q    <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid_q     <= axi_arid;
                        raddr_q   <= axi_araddr;
                        rlen_q    <= axi_arlen;
                        rsize_q   <= axi_arsize;
                        rburst_q  <= axi_arburst;
                        rcnt_q    <= '0;
                        rerr_q    <= ar_err;
                        rresp_q   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rdata_q   <= ar_err ? '0 : mem[word_idx(axi_araddr)];
                        rlast_q   <= (axi_arlen == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_d;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                            rdata_q <= rerr_q ? '0 : mem[word_idx(raddr_d)];
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = bid_q;
    assign axi_bresp   = bresp_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rlast_q;
    assign axi_rid     = rid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed self-checking bench for axi_slave_ram in its default build (error feature off).
module tb_axi_slave_ram;

    logic        aclk = 1'b0;
    logic        areset;
    logic [0:0]  axi_awid, axi_bid, axi_arid, axi_rid;
    logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
    logic [7:0]  axi_awlen, axi_arlen;
    logic [2:0]  axi_awsize, axi_arsize;
    logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic [3:0]  axi_wstrb;
    logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rlast, axi_rvalid, axi_rready;

    int errors = 0;
    int checks = 0;

    logic [31:0] wbuf [0:255];
    logic [31:0] rbuf [0:255];
    logic        rlb  [0:255];
    logic [31:0] incrData [0:31];

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    axi_slave_ram dut (
        .aclk(aclk), .areset(areset),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 aclk = ~aclk;

    // Inputs change 1 time unit after a rising edge, so outputs seen then are what the next edge samples.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input bit gaps, input int breadyDelay,
                            output logic [1:0] resp, output bit bHeld);
        int  guard;
        int  beat;
        bit  hs;
        bit  ph;
        axi_awid = 1'b1; axi_awaddr = addr; axi_awlen = len; axi_awsize = 3'd2;
        axi_awburst = burst; axi_awvalid = 1'b1;
        hs = 1'b0; guard = 0;
        while (!hs && guard < 100) begin
            hs = axi_awready;
            @(posedge aclk); #1; guard++;
        end
        axi_awvalid = 1'b0;
        if (!hs) begin
            checks++; errors++;
            $display("[TB] FAIL aw_handshake: awready=%b required=1 within 100 cycles", axi_awready);
        end
        beat = 0; guard = 0; ph = 1'b0;
        while (beat <= int'(len) && guard < 1000) begin
            if (gaps && ph) begin
                axi_wvalid = 1'b0;
            end else begin
                axi_wvalid = 1'b1;
                axi_wdata  = wbuf[beat];
                axi_wlast  = (beat == int'(len));
            end
            axi_wstrb = strb;
            ph = !ph;
            hs = axi_wvalid && axi_wready;
            @(posedge aclk); #1; guard++;
            if (hs) beat++;
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        if (beat <= int'(len)) begin
            checks++; errors++;
            $display("[TB] FAIL w_beats: accepted=%0d required=%0d", beat, int'(len) + 1);
        end
        guard = 0;
        while (!axi_bvalid && guard < 100) begin
            @(posedge aclk); #1; guard++;
        end
        bHeld = axi_bvalid;
        for (int i = 0; i < breadyDelay; i++) begin
            @(posedge aclk); #1;
            bHeld = bHeld && axi_bvalid;
        end
        resp = axi_bresp;
        axi_bready = 1'b1;
        @(posedge aclk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle, output int stallErr);
        int          guard;
        int          cnt;
        bit          hs;
        bit          ph;
        logic        v;
        logic        l;
        logic [31:0] d;
        axi_arid = 1'b1; axi_araddr = addr; axi_arlen = len; axi_arsize = 3'd2;
        axi_arburst = burst; axi_arvalid = 1'b1;
        hs = 1'b0; guard = 0;
        while (!hs && guard < 100) begin
            hs = axi_arready;
            @(posedge aclk); #1; guard++;
        end
        axi_arvalid = 1'b0;
        if (!hs) begin
            checks++; errors++;
            $display("[TB] FAIL ar_handshake: arready=%b required=1 within 100 cycles", axi_arready);
        end
        cnt = 0; guard = 0; ph = 1'b0; stallErr = 0;
        while (cnt <= int'(len) && guard < 1000) begin
            axi_rready = toggle ? ph : 1'b1;
            ph = !ph;
            v = axi_rvalid; d = axi_rdata; l = axi_rlast;
            @(posedge aclk); #1; guard++;
            if (v && axi_rready) begin
                rbuf[cnt] = d; rlb[cnt] = l; cnt++;
            end else if (v && (axi_rvalid !== 1'b1 || axi_rdata !== d || axi_rlast !== l)) begin
                stallErr++;
            end
        end
        axi_rready = 1'b0;
        if (cnt <= int'(len)) begin
            checks++; errors++;
            $display("[TB] FAIL r_beats: received=%0d required=%0d", cnt, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        #1;
        checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake_outs: got=%b required=000000",
                     {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast});
        end
        checks++;
        if ({axi_bresp, axi_rresp, axi_bid, axi_rid, axi_rdata} !== 38'b0) begin
            errors++;
            $display("[TB] FAIL reset_payload: bresp=%b rresp=%b bid=%b rid=%b rdata=%h required all 0",
                     axi_bresp, axi_rresp, axi_bid, axi_rid, axi_rdata);
        end
        @(posedge aclk); @(posedge aclk); @(negedge aclk);
        areset = 1'b0;
        #1;
        checks++;
        if (axi_awready !== 1'b0 || axi_arready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_before_edge: awready=%b arready=%b required=0 0", axi_awready, axi_arready);
        end
        @(posedge aclk); #1;
        checks++;
        if (axi_awready !== 1'b1 || axi_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_edge: awready=%b arready=%b required=1 1", axi_awready, axi_arready);
        end
    endtask

    task automatic test_incr_burst();
        logic [1:0] resp;
        bit         held;
        int         se;
        for (int i = 0; i < 32; i++) incrData[i] = (32'h0101_0101 * i) ^ 32'h5A5A_0000;
        incrData[0]  = 32'h6434_3962;
        incrData[1]  = 32'h3962_3732;
        incrData[31] = 32'h0002_0000;
        for (int i = 0; i < 32; i++) wbuf[i] = incrData[i];
        do_write(32'h8000_0000, 8'd31, INCR, 4'hF, 1'b0, 0, resp, held);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL incr_bresp: got=%b required=00", resp);
        end
        checks++;
        if (axi_bid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL incr_bid: got=%b required=1", axi_bid);
        end
        do_read(32'h0000_0000, 8'd31, INCR, 1'b0, se);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (rbuf[i] !== incrData[i]) begin
                errors++;
                $display("[TB] FAIL incr_rdata[%0d]: got=%h required=%h", i, rbuf[i], incrData[i]);
            end
            checks++;
            if (rlb[i] !== (i == 31)) begin
                errors++;
                $display("[TB] FAIL incr_rlast[%0d]: got=%b required=%b", i, rlb[i], (i == 31));
            end
        end
        checks++;
        if (axi_rid !== 1'b1 || axi_rresp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL incr_rid_rresp: rid=%b rresp=%b required=1 00", axi_rid, axi_rresp);
        end
    endtask

    task automatic test_gapped_write();
        logic [1:0] resp;
        bit         held;
        int         se;
        @(posedge aclk); #1;
        for (int i = 0; i < 32; i++) wbuf[i] = 32'hC0DE_0000 | i;
        do_write(32'h0000_0100, 8'd31, INCR, 4'hF, 1'b1, 3, resp, held);
        checks++;
        if (!held) begin
            errors++;
            $display("[TB] FAIL bvalid_hold: held=%b required=1", held);
        end
        checks++;
        if (axi_bvalid !== 1'b0 || axi_awready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_bresp: bvalid=%b awready=%b required=0 1", axi_bvalid, axi_awready);
        end
        do_read(32'h0000_0100, 8'd31, INCR, 1'b0, se);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (rbuf[i] !== (32'hC0DE_0000 | i)) begin
                errors++;
                $display("[TB] FAIL gap_rdata[%0d]: got=%h required=%h", i, rbuf[i], 32'hC0DE_0000 | i);
            end
        end
    endtask

    task automatic test_wrap_fixed();
        logic [1:0]  resp;
        bit          held;
        int          se;
        logic [31:0] expWrap [0:3];
        wbuf[0] = 32'hAAAA_000A; wbuf[1] = 32'hBBBB_000B;
        wbuf[2] = 32'hCCCC_000C; wbuf[3] = 32'hDDDD_000D;
        do_write(32'h0000_000C, 8'd3, WRAP, 4'hF, 1'b0, 0, resp, held);
        expWrap[0] = 32'hBBBB_000B; expWrap[1] = 32'hCCCC_000C;
        expWrap[2] = 32'hDDDD_000D; expWrap[3] = 32'hAAAA_000A;
        do_read(32'h0000_0000, 8'd3, INCR, 1'b0, se);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rbuf[i] !== expWrap[i]) begin
                errors++;
                $display("[TB] FAIL wrap_word[%0d]: got=%h required=%h", i, rbuf[i], expWrap[i]);
            end
        end
        do_read(32'h0000_0004, 8'd3, FIXED, 1'b0, se);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rbuf[i] !== 32'hCCCC_000C || rlb[i] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL fixed_beat[%0d]: data=%h last=%b required=cccc000c %b",
                         i, rbuf[i], rlb[i], (i == 3));
            end
        end
    endtask

    task automatic test_rready_strobe();
        logic [1:0]  resp;
        bit          held;
        int          se;
        logic [31:0] expTog [0:7];
        expTog[0] = 32'hBBBB_000B; expTog[1] = 32'hCCCC_000C;
        expTog[2] = 32'hDDDD_000D; expTog[3] = 32'hAAAA_000A;
        for (int i = 4; i < 8; i++) expTog[i] = incrData[i];
        do_read(32'h0000_0000, 8'd7, INCR, 1'b1, se);
        checks++;
        if (se != 0) begin
            errors++;
            $display("[TB] FAIL stall_stability: changes=%0d required=0", se);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rbuf[i] !== expTog[i] || rlb[i] !== (i == 7)) begin
                errors++;
                $display("[TB] FAIL toggle_beat[%0d]: data=%h last=%b required=%h %b",
                         i, rbuf[i], rlb[i], expTog[i], (i == 7));
            end
        end
        wbuf[0] = 32'h1122_3344;
        do_write(32'h0000_0300, 8'd0, INCR, 4'hF, 1'b0, 0, resp, held);
        wbuf[0] = 32'hAAAA_BBBB;
        do_write(32'h0000_0300, 8'd0, INCR, 4'b0011, 1'b0, 0, resp, held);
        do_read(32'h0000_0300, 8'd0, INCR, 1'b0, se);
        checks++;
        if (rbuf[0] !== 32'h1122_BBBB || rlb[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL strobe_merge: data=%h last=%b required=1122bbbb 1", rbuf[0], rlb[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp;
        bit         held;
        int         se;
        wbuf[0] = 32'h0000_1FC0; wbuf[1] = 32'h0000_2000;
        do_write(32'h0000_01FC, 8'd1, INCR, 4'hF, 1'b0, 0, resp, held);
        wbuf[0] = 32'hFEED_BEEF;
        fork
            begin
                do_write(32'h0000_0200, 8'd0, INCR, 4'hF, 1'b0, 0, resp, held);
            end
            begin
                do_read(32'h0000_01FC, 8'd1, INCR, 1'b0, se);
            end
        join
        checks++;
        if (rbuf[0] !== 32'h0000_1FC0 || rbuf[1] !== 32'h0000_2000) begin
            errors++;
            $display("[TB] FAIL concurrent_old_data: got=%h %h required=00001fc0 00002000", rbuf[0], rbuf[1]);
        end
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL concurrent_bresp: got=%b required=00", resp);
        end
        do_read(32'h0000_0200, 8'd0, INCR, 1'b0, se);
        checks++;
        if (rbuf[0] !== 32'hFEED_BEEF) begin
            errors++;
            $display("[TB] FAIL concurrent_write_lands: got=%h required=feedbeef", rbuf[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int guard;
        int beats;
        bit hs;
        axi_arid = 1'b0; axi_araddr = 32'h0; axi_arlen = 8'd15; axi_arsize = 3'd2;
        axi_arburst = INCR; axi_arvalid = 1'b1;
        hs = 1'b0; guard = 0;
        while (!hs && guard < 100) begin
            hs = axi_arready;
            @(posedge aclk); #1; guard++;
        end
        axi_arvalid = 1'b0;
        axi_rready = 1'b1;
        beats = 0; guard = 0;
        while (beats < 5 && guard < 100) begin
            hs = axi_rvalid;
            @(posedge aclk); #1; guard++;
            if (hs) beats++;
        end
        checks++;
        if (axi_rvalid !== 1'b1 || axi_rlast !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_read_active: rvalid=%b rlast=%b required=1 0", axi_rvalid, axi_rlast);
        end
        areset = 1'b1;
        #1;
        checks++;
        if (axi_rvalid !== 1'b0 || axi_arready !== 1'b0 || axi_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: rvalid=%b arready=%b rdata=%h required=0 0 00000000",
                     axi_rvalid, axi_arready, axi_rdata);
        end
        axi_rready = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (axi_arready !== 1'b1 || axi_rvalid !== 1'b0 || axi_awready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_release: arready=%b rvalid=%b awready=%b required=1 0 1",
                     axi_arready, axi_rvalid, axi_awready);
        end
    endtask

    initial begin
        areset = 1'b1;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = 3'd2; axi_awburst = INCR;
        axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = 4'hF; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = 3'd2;
        axi_arburst = INCR; axi_arvalid = 1'b0; axi_rready = 1'b0;
        test_reset();
        test_incr_burst();
        test_gapped_write();
        test_wrap_fixed();
        test_rready_strobe();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/axi_slave_ram.md
# axi_slave_ram

AXI4 memory-mapped slave backed by an internal word-addressed RAM; the responder end of the AXI master used in simulation benches. Accepts one write burst and one read burst concurrently on independent FSMs, supporting FIXED, INCR and WRAP bursts with byte strobes. Sits on the bus as the target for master traffic, for protocol bring-up and as a scratch memory in larger benches.

## Interface
- AXI_ID_WIDTH, 1, width of awid/bid/arid/rid
- AXI_DATA_WIDTH, 32, data width; strobe width is AXI_DATA_WIDTH/8
- AXI_ADDR_WIDTH, 32, address width
- MEM_DEPTH_LOG2, 10, log2 of RAM depth in words

- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset, asynchronous, active-high
- axi_awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid  in  per params  write address
- axi_awready  out  1
- axi_wdata/wstrb/wlast/wvalid  in  per params  write data
- axi_wready  out  1
- axi_bid  out  AXI_ID_WIDTH; axi_bresp  out  2; axi_bvalid  out  1; axi_bready  in  1
- axi_arid/araddr/arlen[7:0]/arsize[2:0]/arburst[1:0]/arvalid  in  per params  read address
- axi_arready  out  1
- axi_rid  out  AXI_ID_WIDTH; axi_rdata  out  AXI_DATA_WIDTH; axi_rresp  out  2; axi_rlast  out  1; axi_rvalid  out  1; axi_rready  in  1

## Operation
- Word index = addr[MEM_DEPTH_LOG2+log2(AXI_DATA_WIDTH/8)-1 : log2(AXI_DATA_WIDTH/8)]; upper bits ignored (see Configuration).
- Beat increment = 1<<size bytes. FIXED: address constant. INCR: addr+increment. WRAP: len must be 1/3/7/15; wrap boundary = (len+1)*increment, aligned; address wraps to boundary base. Burst 2'b11 treated as INCR.
- Write FSM: W_IDLE (awready=1) -> on aw handshake latch id/addr/len/size/burst, beat count=0 -> W_DATA (wready=1). Each wvalid&&wready beat writes bytes with wstrb=1 into RAM, advances address, count++. Beat with count==len -> W_RESP (wready=0, bvalid=1, bid=latched id, bresp=OKAY). bvalid held until bready -> W_IDLE.
- Beat count governs burst end; wlast is not used for termination.
- Read FSM: R_IDLE (arready=1) -> on ar handshake latch fields -> R_DATA. rdata registered from RAM at current address; rlast=1 when count==len. rvalid/rdata/rlast/rid held stable while !rready. On rvalid&&rready of last beat -> R_IDLE.
- rresp=OKAY in default build. RAM contents not reset.
- Same-cycle write and read to same word: read beat returns pre-write data.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0. awready/arready rise on first aclk edge after reset deasserts.
- Reset asserted mid-burst: all outputs to reset values immediately; burst abandoned; partially written words keep written data.
- aw handshake at edge N: awready=0, wready=1 from N+1.
- wvalid gaps permitted; wready stays 1 throughout W_DATA.
- Last w beat at edge M: bvalid=1 from M+1; awready=1 the cycle after the b handshake.
- ar handshake at edge N: rvalid=1 from N+1. With rready held high, one beat per cycle (next beat presented the cycle after each handshake).
- arready=1 the cycle after the last r handshake.
- Write and read channels fully independent; no mutual stalls.

## Configuration
- AXI_SLAVE_ERR_EN defined: bursts whose start or any beat address has a nonzero bit above the word-index range, or burst 2'b11, or WRAP with illegal len, complete normally in handshake but suppress RAM writes and return SLVERR (2'b10) in bresp / every rresp beat (rdata=0). Writes whose last-counted beat lacks wlast, or wlast early, return SLVERR (writes still performed).
- Not defined: upper address bits ignored (RAM aliases modulo depth), responses always OKAY, wlast ignored.

## Test plan
- INCR write 32 beats at 0x8000_0000 (data 0x64343962, 0x39623732, ..., 0x00020000), then INCR read 32 beats at 0x0000_0000 (macro off) -> bresp=OKAY, read data matches word for word, rlast only on beat 31.
- Write with wvalid deasserted every other cycle, awready sampled one cycle late -> all 32 words written, bvalid held until bready pulsed 3 cycles after bvalid.
- WRAP len=3 write at 0x0C of words A,B,C,D -> RAM words 3,0,1,2 = A,B,C,D; FIXED read len=3 at 0x04 returns word 1 four times.
- Read with rready toggling 1/0 -> rdata/rlast stable during stalls; strobe write 4'b0011 of 0xAAAA_BBBB over 0x1122_3344 -> readback 0x1122_BBBB.
- Concurrent write burst and read burst overlapping same address in same cycle -> read returns old value, write lands; neither channel stalls.
- Macro on: write to 0x8000_0000 with MEM_DEPTH_LOG2=10 -> bresp=SLVERR, RAM unchanged; reset asserted at beat 5 of read -> rvalid=0 immediately, arready=1 one edge after release.
